// File: rtl/global_defs.sv
// Shared definitions for the parser/queue datapath.
//   ADDRESS_WIDTH : width of a parsed address
//   parsed_op_t   : opcode classes produced by the parser
package global_defs;

    localparam int unsigned ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        DATA_READ    = 2'd0,
        DATA_WRITE   = 2'd1,
        OPCODE_FETCH = 2'd2,
        NOP          = 2'd3
    } parsed_op_t;

endpackage

// File: rtl/request_queue.sv
// request_queue: circular FIFO of parsed operations with a per-entry age counter.
//   clock, reset_n      : clock, asynchronous active-low reset
//   in_valid/op/addr    : parser push side; NOP operations are dropped
//   in_ready            : queue not full (registered state only)
//   out_valid/op/addr   : head entry, read combinationally from storage
//   out_age             : cycles the head entry has waited (saturating)
//   out_pop             : consumer removes head
//   count, full, empty  : occupancy status
module request_queue
    import global_defs::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AGE_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  parsed_op_t               in_op,
    input  logic [ADDRESS_WIDTH-1:0] in_addr,
    output logic                     in_ready,
    output logic                     out_valid,
    output parsed_op_t               out_op,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [AGE_WIDTH-1:0]     out_age,
    input  logic                     out_pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    parsed_op_t               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic [AGE_WIDTH-1:0]     age_mem  [DEPTH];
    logic [DEPTH-1:0]         occupied;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic push_c;
    logic pop_c;

    // Status flags come straight from the registered occupancy count.
    always_comb begin
        empty    = (count_q == CNT_W'(0));
        full     = (count_q == CNT_W'(DEPTH));
        count    = count_q;
        in_ready = !full;
    end

    // Transfer qualifiers.
    always_comb begin
        push_c = in_valid && in_ready && (in_op != NOP);
        pop_c  = out_pop && !empty;
    end

    // Head view; forced to an idle NOP/0/0 when the queue is empty.
    always_comb begin
        out_valid = !empty;
        out_op    = NOP;
        out_addr  = '0;
        out_age   = '0;
        if (!empty) begin
            out_op   = op_mem[rd_ptr];
            out_addr = addr_mem[rd_ptr];
            out_age  = age_mem[rd_ptr];
        end
    end

    // Pointers and occupancy count; power-of-two depth makes the wrap free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage, occupancy bits and ages. A slot cannot be pushed and
    // popped on the same edge: that would need count to be both 0 and DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occupied <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_mem[i]   <= NOP;
                addr_mem[i] <= '0;
                age_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_c && (wr_ptr == PTR_W'(i))) begin
                    op_mem[i]   <= in_op;
                    addr_mem[i] <= in_addr;
                    age_mem[i]  <= '0;
                    occupied[i] <= 1'b1;
                end else begin
                    if (pop_c && (rd_ptr == PTR_W'(i))) begin
                        occupied[i] <= 1'b0;
                    end
                    // Age only live entries; a freed slot restarts at 0 on reuse.
                    if (occupied[i] && (age_mem[i] != AGE_MAX)) begin
                        age_mem[i] <= age_mem[i] + AGE_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_request_queue.sv
module tb_request_queue;
    import global_defs::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AGE_W = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct {
        parsed_op_t  op;
        logic [31:0] addr;
    } entry_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    parsed_op_t        in_op = NOP;
    logic [31:0]       in_addr = '0;
    logic              in_ready;
    logic              out_valid;
    parsed_op_t        out_op;
    logic [31:0]       out_addr;
    logic [AGE_W-1:0]  out_age;
    logic              out_pop = 1'b0;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    entry_t sb[$];
    int     mdl_count = 0;
    int     passed = 0;
    int     failed = 0;
    int     total  = 0;

    request_queue #(.DEPTH(DEPTH), .AGE_WIDTH(AGE_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_op    (out_op),
        .out_addr  (out_addr),
        .out_age   (out_age),
        .out_pop   (out_pop),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One clock of optional push and/or pop. The model decides acceptance from
    // pre-edge occupancy; popped heads are compared against the scoreboard.
    task automatic cycle(input bit do_push, input parsed_op_t op, input logic [31:0] addr,
                         input bit do_pop, input string tag);
        entry_t e;
        bit push_ok;
        bit pop_ok;
        push_ok = do_push && (mdl_count < DEPTH) && (op != NOP);
        pop_ok  = do_pop && (mdl_count > 0);
        if (pop_ok) begin
            e = sb.pop_front();
            check({tag, "_head_addr"}, 64'(out_addr), 64'(e.addr));
            check({tag, "_head_op"}, 64'(out_op), 64'(e.op));
        end
        if (push_ok) begin
            e.op = op;
            e.addr = addr;
            sb.push_back(e);
        end
        mdl_count = mdl_count + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
        in_valid = do_push;
        in_op    = op;
        in_addr  = addr;
        out_pop  = do_pop;
        tick();
        in_valid = 1'b0;
        in_op    = NOP;
        out_pop  = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (mdl_count > 0) cycle(1'b0, NOP, 32'h0, 1'b1, tag);
        check({tag, "_empty"}, 64'(empty), 64'(1));
        check({tag, "_count"}, 64'(count), 64'(0));
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        #2;
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full", 64'(full), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_op", 64'(out_op), 64'(NOP));
        check("rst_out_addr", 64'(out_addr), 64'(0));
        check("rst_out_age", 64'(out_age), 64'(0));
        reset_n = 1'b1;

        // First edge after release accepts; entry visible right after it with age 0.
        cycle(1'b1, DATA_READ, 32'h0000_1000, 1'b0, "first");
        check("first_valid", 64'(out_valid), 64'(1));
        check("first_op", 64'(out_op), 64'(DATA_READ));
        check("first_addr", 64'(out_addr), 64'(32'h0000_1000));
        check("first_age0", 64'(out_age), 64'(0));
        check("first_count", 64'(count), 64'(1));
        repeat (5) tick();
        check("first_age5", 64'(out_age), 64'(5));
        drain("first_drain");

        // Fill to capacity, overflow push ignored, drain in order.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, parsed_op_t'(2'(i % 3)), 32'(i), 1'b0, "fill");
        check("fill_full", 64'(full), 64'(1));
        check("fill_in_ready", 64'(in_ready), 64'(0));
        check("fill_count", 64'(count), 64'(16));
        cycle(1'b1, DATA_WRITE, 32'd99, 1'b0, "overflow");
        check("overflow_count", 64'(count), 64'(16));
        check("overflow_head", 64'(out_addr), 64'(0));
        drain("fill_drain");
        check("fill_drain_op", 64'(out_op), 64'(NOP));
        check("fill_drain_addr", 64'(out_addr), 64'(0));

        // Full queue: push+pop -> only pop taken; then refill wraps write pointer.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, DATA_WRITE, 32'h100 + 32'(i), 1'b0, "refill");
        cycle(1'b1, OPCODE_FETCH, 32'h200, 1'b1, "fullpp");
        check("fullpp_count", 64'(count), 64'(15));
        check("fullpp_ready", 64'(in_ready), 64'(1));
        cycle(1'b1, OPCODE_FETCH, 32'h201, 1'b0, "wrap");
        check("wrap_count", 64'(count), 64'(16));
        check("wrap_full", 64'(full), 64'(1));
        drain("wrap_drain");

        // Steady state at count 4 with simultaneous push/pop.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, DATA_READ, 32'h300 + 32'(i), 1'b0, "pp_fill");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, parsed_op_t'(2'(i % 3)), 32'h400 + 32'(i), 1'b1, "pp");
            check("pp_count", 64'(count), 64'(4));
        end
        drain("pp_drain");

        // NOP discard and pop-on-empty.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, NOP, 32'hFFFF_FFFF, 1'b0, "nop");
        check("nop_count", 64'(count), 64'(0));
        check("nop_empty", 64'(empty), 64'(1));
        cycle(1'b0, NOP, 32'h0, 1'b1, "pop_empty");
        check("pop_empty_count", 64'(count), 64'(0));
        check("pop_empty_valid", 64'(out_valid), 64'(0));

        // Age saturation, and a later entry starting fresh at 0.
        cycle(1'b1, DATA_WRITE, 32'h0000_0ACE, 1'b0, "age");
        repeat (300) tick();
        check("age_sat", 64'(out_age), 64'(255));
        cycle(1'b1, DATA_READ, 32'h0000_0BEE, 1'b1, "age_next");
        check("age_next_age", 64'(out_age), 64'(0));
        check("age_next_addr", 64'(out_addr), 64'(32'h0000_0BEE));
        drain("age_drain");

        // Mid-cycle reset with 7 entries; activity during reset has no effect.
        for (int i = 0; i < 7; i++)
            cycle(1'b1, DATA_READ, 32'h500 + 32'(i), 1'b0, "pre_rst");
        check("pre_rst_count", 64'(count), 64'(7));
        #3;
        reset_n = 1'b0;
        #1;
        check("mrst_count", 64'(count), 64'(0));
        check("mrst_valid", 64'(out_valid), 64'(0));
        check("mrst_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_op    = DATA_READ;
        in_addr  = 32'h1234;
        out_pop  = 1'b1;
        tick();
        check("mrst_hold_count", 64'(count), 64'(0));
        in_valid = 1'b0;
        in_op    = NOP;
        out_pop  = 1'b0;
        #2;
        reset_n = 1'b1;
        sb.delete();
        mdl_count = 0;
        cycle(1'b1, DATA_WRITE, 32'hDEAD_BEEF, 1'b0, "post_rst");
        check("post_rst_addr", 64'(out_addr), 64'(32'hDEAD_BEEF));
        check("post_rst_op", 64'(out_op), 64'(DATA_WRITE));
        check("post_rst_count", 64'(count), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/request_queue.md
REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning:
- DEPTH, 16, number of queue entries (power of two, >= 2)
- AGE_WIDTH, 8, width of per-entry age counter
REQ-002 The block SHALL use ADDRESS_WIDTH (32) and parsed_op_t (DATA_READ=0, DATA_WRITE=1, OPCODE_FETCH=2, NOP=3) from global_defs.
REQ-003 The block SHALL have ports, one per line: name, direction, width, meaning:
- clock  in  1  sole clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  parser presents an operation this cycle
- in_op  in  parsed_op_t  parsed opcode
- in_addr  in  ADDRESS_WIDTH  parsed address
- in_ready  out  1  queue can accept an entry
- out_valid  out  1  head entry present
- out_op  out  parsed_op_t  head opcode
- out_addr  out  ADDRESS_WIDTH  head address
- out_age  out  AGE_WIDTH  cycles head entry has waited
- out_pop  in  1  consumer removes head this cycle
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Function
REQ-004 The block SHALL be a circular FIFO with read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-005 in_ready SHALL equal !full, derived from registered state only (no combinational path from out_pop).
REQ-006 A push SHALL occur when in_valid && in_ready && in_op != NOP; in_op/in_addr are written at the write pointer and the write pointer advances by 1.
REQ-007 in_valid with in_op == NOP SHALL be discarded with no state change.
REQ-008 in_valid while full SHALL be ignored; the producer holds its operation until in_ready is 1.
REQ-009 A pop SHALL occur when out_pop && out_valid; the read pointer advances by 1; out_pop while empty is ignored.
REQ-010 out_valid SHALL equal !empty; out_op/out_addr/out_age SHALL reflect the entry at the read pointer combinationally from storage.
REQ-011 When empty, out_op SHALL be NOP, out_addr 0, out_age 0.
REQ-012 Latency: an entry pushed at edge N SHALL be visible on the outputs after edge N (no same-cycle bypass when empty).
REQ-013 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-014 count SHALL update as +1 (push only), -1 (pop only), unchanged (both or neither).
REQ-015 A newly pushed entry's age SHALL be 0; every occupied entry's age SHALL increment by 1 per edge thereafter, saturating at 2^AGE_WIDTH-1.
REQ-016 A popped slot's age SHALL not affect any later entry; a reused slot starts at age 0.
REQ-017 Entries SHALL leave strictly in push order.

Reset
REQ-018 While reset_n is 0, asynchronously: pointers 0, count 0, empty 1, full 0, in_ready 1, out_valid 0, out_op NOP, out_addr 0, out_age 0, all ages 0.
REQ-019 Assertion of reset_n mid-operation SHALL discard all entries immediately; pushes/pops in that cycle have no effect.
REQ-020 The first push SHALL be accepted on the first rising edge with reset_n 1.

Verification
REQ-021 Push READ@0x0000_1000 at cycle 0, no pop -> next cycle out_valid=1, out_op=DATA_READ, out_addr=0x0000_1000, out_age=0; after 5 more edges out_age=5.
REQ-022 16 pushes (addr 0..15), no pops -> full=1, in_ready=0, count=16; 17th push (addr 99) ignored; 16 pops return addr 0..15 in order, then empty=1, out_op=NOP.
REQ-023 Full queue, push and pop same cycle -> pop accepted, push ignored, count=15; next cycle push accepted, count=16; write pointer wraps to slot 0.
REQ-024 count=4, simultaneous push/pop for 10 cycles -> count stays 4, output order matches push order.
REQ-025 in_valid with in_op=NOP for 3 cycles -> count stays 0; out_pop on empty -> no change; head held 300 cycles -> out_age=255.
REQ-026 count=7, reset_n driven low between edges -> immediately count=0, out_valid=0, in_ready=1; after release, push WRITE@0xDEAD_BEEF -> out_addr=0xDEAD_BEEF, count=1.
